// File: rtl/fir_mc_pkg.sv
// Shared types, default coefficient table and width/limit helpers for the
// time-multiplexed multichannel FIR filter.
package fir_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_TABLE_NTAP = 16;

    // Symmetric low-pass table; only the first half is stored, the rest mirrors it.
    function automatic int default_coef(int ntap, int idx);
        int m;
        if (ntap != DEFAULT_TABLE_NTAP) begin
            return 0;
        end
        m = (idx < 8) ? idx : (15 - idx);
        case (m)
            0:       return 311;
            1:       return 469;
            2:       return 917;
            3:       return 1582;
            4:       return 2352;
            5:       return 3091;
            6:       return 3671;
            7:       return 3990;
            default: return 0;
        endcase
    endfunction

    function automatic int acc_w(int din_w, int coef_w, int ntap);
        return din_w + coef_w + $clog2(ntap);
    endfunction

    function automatic longint sat_max(int dout_w);
        return (longint'(1) <<< (dout_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(int dout_w);
        return -(longint'(1) <<< (dout_w - 1));
    endfunction

endpackage

// File: rtl/fir_filter_mc_round_sat.sv
// Output conditioning: round half up, arithmetic shift right, clamp to the
// signed output range and report whether clamping happened.
module fir_round_sat
    import fir_mc_pkg::*;
#(
    parameter int ACC_W  = 34,
    parameter int SHIFT  = 14,
    parameter int DOUT_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     sat
);

    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(longint'(1) <<< (SHIFT - 1));
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(sat_max(DOUT_W));
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(sat_min(DOUT_W));

    // One guard bit so adding the rounding constant can never wrap.
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        rounded = {acc[ACC_W-1], acc} + HALF;
        shifted = rounded >>> SHIFT;
        sat     = 1'b0;
        dout    = shifted[DOUT_W-1:0];
        if (shifted > MAX_V) begin
            dout = MAX_V[DOUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            dout = MIN_V[DOUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_mc.sv
// Multichannel FIR: one shared MAC walks NTAP taps per sample, with a circular
// delay line per channel and a runtime-writable coefficient bank.
module fir_filter_mc
    import fir_mc_pkg::*;
#(
    parameter int NTAP   = 16,
    parameter int NCH    = 2,
    parameter int DIN_W  = 14,
    parameter int COEF_W = 16,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 14,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int ADDR_W = $clog2(NTAP)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic signed [DIN_W-1:0]  din,
    input  logic [CH_W-1:0]          din_ch,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     coef_err,
    output logic signed [DOUT_W-1:0] dout,
    output logic [CH_W-1:0]          dout_ch,
    output logic                     dout_valid,
    output logic                     sat_flag
);

    localparam int ACC_W  = acc_w(DIN_W, COEF_W, NTAP);
    localparam int PROD_W = DIN_W + COEF_W;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]        tap_reg;
    logic [ADDR_W-1:0]        rd_idx_reg;
    logic [CH_W-1:0]          ch_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     coef_err_reg;
    logic signed [DOUT_W-1:0] dout_reg;
    logic [CH_W-1:0]          dout_ch_reg;
    logic                     dout_valid_reg;
    logic                     sat_reg;

    logic                     ch_ok;
    logic                     addr_ok;
    logic                     start;
    logic                     coef_ok;
    logic signed [PROD_W-1:0] prod;
    logic signed [DOUT_W-1:0] rs_dout;
    logic                     rs_sat;

    logic signed [DIN_W-1:0]  ch_sample [NCH];
    logic [ADDR_W-1:0]        ch_ptr    [NCH];
    logic signed [COEF_W-1:0] coef_val  [NTAP];

    // Extra MSB keeps the range checks meaningful when NCH/NTAP are powers of two.
    assign ch_ok   = {1'b0, din_ch} < (CH_W+1)'(NCH);
    assign addr_ok = {1'b0, coef_addr} < (ADDR_W+1)'(NTAP);

    assign din_ready = (state_reg == IDLE);
    assign start     = din_ready && din_valid && ch_ok;
    assign coef_ok   = coef_we && (state_reg == IDLE) && addr_ok;

    genvar gi;

    // Per-channel circular delay line; the pointer marks the next write slot.
    for (gi = 0; gi < NCH; gi++) begin : gen_ch
        logic signed [DIN_W-1:0] line_reg [NTAP];
        logic [ADDR_W-1:0]       ptr_reg;
        logic                    wr_en;

        assign wr_en = start && (din_ch == CH_W'(gi));

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                ptr_reg <= '0;
                for (int t = 0; t < NTAP; t++) begin
                    line_reg[t] <= '0;
                end
            end else if (wr_en) begin
                line_reg[ptr_reg] <= din;
                ptr_reg <= (ptr_reg == ADDR_W'(NTAP - 1)) ? '0 : ptr_reg + 1'b1;
            end
        end

        assign ch_sample[gi] = line_reg[rd_idx_reg];
        assign ch_ptr[gi]    = ptr_reg;
    end

    for (gi = 0; gi < NTAP; gi++) begin : gen_tap
        logic signed [COEF_W-1:0] coef_reg;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                coef_reg <= COEF_W'(default_coef(NTAP, gi));
            end else if (coef_ok && (coef_addr == ADDR_W'(gi))) begin
                coef_reg <= coef_wdata;
            end
        end

        assign coef_val[gi] = coef_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (tap_reg == ADDR_W'(NTAP - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign prod = ch_sample[ch_reg] * coef_val[tap_reg];

    // rd_idx starts on the freshly written slot and walks backwards in time.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= IDLE;
            tap_reg    <= '0;
            rd_idx_reg <= '0;
            ch_reg     <= '0;
            acc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                ch_reg     <= din_ch;
                rd_idx_reg <= ch_ptr[din_ch];
                tap_reg    <= '0;
                acc_reg    <= '0;
            end else if (state_reg == MAC) begin
                acc_reg    <= acc_reg + ACC_W'(prod);
                tap_reg    <= tap_reg + 1'b1;
                rd_idx_reg <= (rd_idx_reg == '0) ? ADDR_W'(NTAP - 1) : rd_idx_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            coef_err_reg <= 1'b0;
        end else if (coef_we && !coef_ok) begin
            coef_err_reg <= 1'b1;
        end
    end

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .DOUT_W (DOUT_W)
    ) u_round_sat (
        .acc  (acc_reg),
        .dout (rs_dout),
        .sat  (rs_sat)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout_reg       <= '0;
            dout_ch_reg    <= '0;
            dout_valid_reg <= 1'b0;
            sat_reg        <= 1'b0;
        end else begin
            dout_valid_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                dout_reg    <= rs_dout;
                dout_ch_reg <= ch_reg;
                sat_reg     <= rs_sat;
            end
        end
    end

    assign coef_err   = coef_err_reg;
    assign dout       = dout_reg;
    assign dout_ch    = dout_ch_reg;
    assign dout_valid = dout_valid_reg;
    assign sat_flag   = sat_reg;

endmodule
